core_pipe_mem: RTL and testbench

Memory-issue stage of the core pipeline, sitting directly upstream of the writeback stage. It accepts an instruction from execute whose effective address and data are already computed. It issues the data-memory request with byte strobes and aligned write data, and detects misaligned accesses. It then hands the instruction across the s3 pipeline register to writeback, timed so that the memory response arrives in the cycle writeback owns the instruction.

---
 rtl/core_pipe_mem_pkg.sv | 49 ++++
 rtl/core_lsu_align.sv | 34 +++
 rtl/core_pipe_mem.sv | 196 +++++++++++++++++++
 tb/tb_core_pipe_mem.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_mem_pkg.sv
// Shared definitions for the memory-issue stage: operand widths, LSU op encoding, trap causes.
package core_pipe_mem_pkg;

  localparam int unsigned CSR_OP_W = 3;
  localparam int unsigned CFU_OP_W = 4;
  localparam int unsigned WB_OP_W  = 2;
  localparam int unsigned LSU_OP_W = 7;

  // One-hot bit positions of s3_lsu_op
  localparam int unsigned LSU_LOAD   = 0;
  localparam int unsigned LSU_STORE  = 1;
  localparam int unsigned LSU_BYTE   = 2;
  localparam int unsigned LSU_HALF   = 3;
  localparam int unsigned LSU_WORD   = 4;
  localparam int unsigned LSU_DOUBLE = 5;
  localparam int unsigned LSU_SEXT   = 6;

  localparam logic [1:0] SIZE_BYTE   = 2'd0;
  localparam logic [1:0] SIZE_HALF   = 2'd1;
  localparam logic [1:0] SIZE_WORD   = 2'd2;
  localparam logic [1:0] SIZE_DOUBLE = 2'd3;

  localparam logic [4:0] TRAP_LDMISALIGN = 5'd4;
  localparam logic [4:0] TRAP_LDACCESS   = 5'd5;
  localparam logic [4:0] TRAP_STMISALIGN = 5'd6;

  typedef enum logic [1:0] {StIdle, StReq, StDrain} mem_state_e;

  function automatic logic [LSU_OP_W-1:0] lsu_encode(input logic       load,
                                                     input logic       store,
                                                     input logic       sext,
                                                     input logic [1:0] size);
    logic [LSU_OP_W-1:0] op;
    op = '0;
    if (load || store) begin
      op[LSU_LOAD]  = load;
      op[LSU_STORE] = store;
      op[LSU_SEXT]  = sext;
      unique case (size)
        SIZE_BYTE: op[LSU_BYTE]   = 1'b1;
        SIZE_HALF: op[LSU_HALF]   = 1'b1;
        SIZE_WORD: op[LSU_WORD]   = 1'b1;
        default:   op[LSU_DOUBLE] = 1'b1;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational store alignment: byte strobes, lane-shifted write data and misalignment detect.
module core_lsu_align
  import core_pipe_mem_pkg::*;
(
  input  logic        mem_op_i,
  input  logic [1:0]  size_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] wdata_i,
  output logic [7:0]  strb_o,
  output logic [63:0] wdata_o,
  output logic        misaligned_o
);

  logic [7:0] mask;

  always_comb begin
    mask = 8'h00;
    unique case (size_i)
      SIZE_BYTE: mask = 8'h01;
      SIZE_HALF: mask = 8'h03;
      SIZE_WORD: mask = 8'h0F;
      default:   mask = 8'hFF;
    endcase
  end

  assign strb_o  = mask << offset_i;
  assign wdata_o = wdata_i << {offset_i, 3'b000};

  assign misaligned_o = mem_op_i &&
                        ((offset_i[0] && (size_i >= SIZE_HALF)) ||
                         (offset_i[1] && (size_i >= SIZE_WORD)) ||
                         (offset_i[2] && (size_i == SIZE_DOUBLE)));

endmodule

// File: rtl/core_pipe_mem.sv
// Memory-issue stage: issues the data request, detects misalignment and fills the s3 register
// so that the memory response lands in the cycle writeback owns the instruction.
module core_pipe_mem
  import core_pipe_mem_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned MEM_ADDR_W = 64
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  flush,
  input  logic                  s2_valid,
  output logic                  s2_ready,
  input  logic [XLEN-1:0]       s2_pc,
  input  logic [XLEN-1:0]       s2_n_pc,
  input  logic [31:0]           s2_instr,
  input  logic [4:0]            s2_rd,
  input  logic [XLEN-1:0]       s2_addr,
  input  logic [XLEN-1:0]       s2_wdata,
  input  logic                  s2_load,
  input  logic                  s2_store,
  input  logic                  s2_sext,
  input  logic [1:0]            s2_size,
  input  logic [CSR_OP_W-1:0]   s2_csr_op,
  input  logic [CFU_OP_W-1:0]   s2_cfu_op,
  input  logic [WB_OP_W-1:0]    s2_wb_op,
  input  logic [11:0]           s2_csr_addr,
  input  logic                  s2_trap,
  input  logic [4:0]            s2_cause,
  output logic                  dmem_req,
  output logic [MEM_ADDR_W-1:0] dmem_addr,
  output logic                  dmem_wen,
  output logic [7:0]            dmem_strb,
  output logic [63:0]           dmem_wdata,
  input  logic                  dmem_gnt,
  output logic                  s3_valid,
  input  logic                  s3_ready,
  output logic                  s3_full,
  output logic [XLEN-1:0]       s3_pc,
  output logic [XLEN-1:0]       s3_n_pc,
  output logic [31:0]           s3_instr,
  output logic [4:0]            s3_rd,
  output logic [XLEN-1:0]       s3_wdata,
  output logic [LSU_OP_W-1:0]   s3_lsu_op,
  output logic [CSR_OP_W-1:0]   s3_csr_op,
  output logic [11:0]           s3_csr_addr,
  output logic [CFU_OP_W-1:0]   s3_cfu_op,
  output logic [WB_OP_W-1:0]    s3_wb_op,
  output logic                  s3_trap
);

  mem_state_e state_q, state_d;

  logic        mem_op, mis, mem_go, issue, discard, hand_valid, handoff;
  logic [7:0]  al_strb;
  logic [63:0] al_wdata;
  logic [4:0]  rd_sel;

  logic [MEM_ADDR_W-1:0] req_addr_q;
  logic                  req_wen_q;
  logic [7:0]            req_strb_q;
  logic [63:0]           req_wdata_q;

  logic s3_full_q, s3_full_d;

  assign mem_op = s2_load | s2_store;

  core_lsu_align u_align (
    .mem_op_i     (mem_op),
    .size_i       (s2_size),
    .offset_i     (s2_addr[2:0]),
    .wdata_i      (64'(s2_wdata)),
    .strb_o       (al_strb),
    .wdata_o      (al_wdata),
    .misaligned_o (mis)
  );

  assign mem_go = mem_op & ~mis & ~s2_trap;

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    discard    = 1'b0;
    hand_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        issue = s2_valid & mem_go & s3_ready & ~flush;
        if (flush) begin
          discard = 1'b1;
        end else if (s2_valid) begin
          if (!mem_go) begin
            hand_valid = 1'b1;
          end else if (issue) begin
            if (dmem_gnt) hand_valid = 1'b1;
            else          state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (dmem_gnt) begin
          if (flush) discard    = 1'b1;
          else       hand_valid = 1'b1;
          state_d = StIdle;
        end else if (flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Flushed request must still complete before the slot is freed
        if (dmem_gnt) begin
          discard = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset masks the request at once so a pending REQ never leaks past reset
  assign dmem_req = g_resetn & (issue | (state_q != StIdle));
  assign s3_valid = g_resetn & hand_valid;
  assign handoff  = s3_valid & s3_ready;
  assign s2_ready = g_resetn & (handoff | discard);

  always_comb begin
    if (state_q == StIdle) begin
      dmem_addr  = {s2_addr[MEM_ADDR_W-1:3], 3'b000};
      dmem_wen   = s2_store;
      dmem_strb  = al_strb;
      dmem_wdata = al_wdata;
    end else begin
      dmem_addr  = req_addr_q;
      dmem_wen   = req_wen_q;
      dmem_strb  = req_strb_q;
      dmem_wdata = req_wdata_q;
    end
  end

  always_comb begin
    if (s2_trap)  rd_sel = s2_cause;
    else if (mis) rd_sel = s2_store ? TRAP_STMISALIGN : TRAP_LDMISALIGN;
    else          rd_sel = s2_rd;
  end

  always_comb begin
    if (handoff)                 s3_full_d = 1'b1;
    else if (flush || s3_ready)  s3_full_d = 1'b0;
    else                         s3_full_d = s3_full_q;
  end

  always_ff @(posedge g_clk) begin
    if (state_q == StIdle && issue) begin
      req_addr_q  <= {s2_addr[MEM_ADDR_W-1:3], 3'b000};
      req_wen_q   <= s2_store;
      req_strb_q  <= al_strb;
      req_wdata_q <= al_wdata;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q     <= StIdle;
      s3_full_q   <= 1'b0;
      s3_pc       <= '0;
      s3_n_pc     <= '0;
      s3_instr    <= '0;
      s3_rd       <= '0;
      s3_wdata    <= '0;
      s3_lsu_op   <= '0;
      s3_csr_op   <= '0;
      s3_csr_addr <= '0;
      s3_cfu_op   <= '0;
      s3_wb_op    <= '0;
      s3_trap     <= 1'b0;
    end else begin
      state_q   <= state_d;
      s3_full_q <= s3_full_d;
      if (handoff) begin
        s3_pc       <= s2_pc;
        s3_n_pc     <= s2_n_pc;
        s3_instr    <= s2_instr;
        s3_rd       <= rd_sel;
        s3_wdata    <= mem_op ? s2_addr : s2_wdata;
        s3_lsu_op   <= lsu_encode(s2_load, s2_store, s2_sext, s2_size);
        s3_csr_op   <= s2_csr_op;
        s3_csr_addr <= s2_csr_addr;
        s3_cfu_op   <= s2_cfu_op;
        s3_wb_op    <= s2_wb_op;
        s3_trap     <= s2_trap | mis;
      end
    end
  end

  assign s3_full = s3_full_q;

endmodule

// File: tb/tb_core_pipe_mem.sv
// Directed bench for core_pipe_mem: aligned/delayed requests, misalignment, flush, reset.
module tb_core_pipe_mem;
  import core_pipe_mem_pkg::*;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned MEM_ADDR_W = 64;

  logic                  g_clk = 1'b0;
  logic                  g_resetn, flush, s2_valid, s2_ready;
  logic [XLEN-1:0]       s2_pc, s2_n_pc, s2_addr, s2_wdata;
  logic [31:0]           s2_instr;
  logic [4:0]            s2_rd, s2_cause;
  logic                  s2_load, s2_store, s2_sext, s2_trap;
  logic [1:0]            s2_size;
  logic [CSR_OP_W-1:0]   s2_csr_op;
  logic [CFU_OP_W-1:0]   s2_cfu_op;
  logic [WB_OP_W-1:0]    s2_wb_op;
  logic [11:0]           s2_csr_addr;
  logic                  dmem_req, dmem_wen, dmem_gnt;
  logic [MEM_ADDR_W-1:0] dmem_addr;
  logic [7:0]            dmem_strb;
  logic [63:0]           dmem_wdata;
  logic                  s3_valid, s3_ready, s3_full, s3_trap;
  logic [XLEN-1:0]       s3_pc, s3_n_pc, s3_wdata;
  logic [31:0]           s3_instr;
  logic [4:0]            s3_rd;
  logic [LSU_OP_W-1:0]   s3_lsu_op;
  logic [CSR_OP_W-1:0]   s3_csr_op;
  logic [11:0]           s3_csr_addr;
  logic [CFU_OP_W-1:0]   s3_cfu_op;
  logic [WB_OP_W-1:0]    s3_wb_op;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 g_clk = ~g_clk;

  core_pipe_mem #(.XLEN(XLEN), .MEM_ADDR_W(MEM_ADDR_W)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_pc(s2_pc), .s2_n_pc(s2_n_pc),
    .s2_instr(s2_instr), .s2_rd(s2_rd), .s2_addr(s2_addr), .s2_wdata(s2_wdata),
    .s2_load(s2_load), .s2_store(s2_store), .s2_sext(s2_sext), .s2_size(s2_size),
    .s2_csr_op(s2_csr_op), .s2_cfu_op(s2_cfu_op), .s2_wb_op(s2_wb_op),
    .s2_csr_addr(s2_csr_addr), .s2_trap(s2_trap), .s2_cause(s2_cause),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
    .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_full(s3_full),
    .s3_pc(s3_pc), .s3_n_pc(s3_n_pc), .s3_instr(s3_instr), .s3_rd(s3_rd),
    .s3_wdata(s3_wdata), .s3_lsu_op(s3_lsu_op), .s3_csr_op(s3_csr_op),
    .s3_csr_addr(s3_csr_addr), .s3_cfu_op(s3_cfu_op), .s3_wb_op(s3_wb_op),
    .s3_trap(s3_trap)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    flush = 1'b0; s2_valid = 1'b0; s2_pc = '0; s2_n_pc = '0; s2_instr = '0;
    s2_rd = '0; s2_addr = '0; s2_wdata = '0; s2_load = 1'b0; s2_store = 1'b0;
    s2_sext = 1'b0; s2_size = 2'd0; s2_csr_op = '0; s2_cfu_op = '0; s2_wb_op = '0;
    s2_csr_addr = '0; s2_trap = 1'b0; s2_cause = '0; dmem_gnt = 1'b0; s3_ready = 1'b1;
  endtask

  task automatic drive_op(input logic [63:0] pc, input logic ld, input logic st,
                          input logic [1:0] sz, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [4:0] rd);
    s2_valid = 1'b1; s2_pc = pc; s2_n_pc = pc + 64'd4; s2_instr = pc[31:0] ^ 32'h13;
    s2_load = ld; s2_store = st; s2_sext = 1'b0; s2_size = sz;
    s2_addr = addr; s2_wdata = wd; s2_rd = rd; s2_trap = 1'b0; s2_cause = '0;
  endtask

  // Writeback contract: s3_ready must stay high while a request is outstanding
  always @(posedge g_clk) begin
    if (g_resetn && dmem_req) check_eq("s3_ready_hold", {63'd0, s3_ready}, 64'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    g_resetn = 1'b0;
    drive_op(64'h40, 1'b1, 1'b0, SIZE_WORD, 64'h8000, 64'h0, 5'd3);
    dmem_gnt = 1'b1;
    repeat (2) @(negedge g_clk);
    #1;
    check_eq("rst_req", {63'd0, dmem_req}, 64'd0);
    check_eq("rst_s3_valid", {63'd0, s3_valid}, 64'd0);
    check_eq("rst_s3_full", {63'd0, s3_full}, 64'd0);
    check_eq("rst_s3_trap", {63'd0, s3_trap}, 64'd0);
    check_eq("rst_s3_pc", s3_pc, 64'd0);

    // Byte store, granted immediately
    @(negedge g_clk);
    g_resetn = 1'b1;
    idle_inputs();
    drive_op(64'h80, 1'b0, 1'b1, SIZE_BYTE, 64'h1003, 64'hAB, 5'd0);
    dmem_gnt = 1'b1;
    #1;
    check_eq("t1_req", {63'd0, dmem_req}, 64'd1);
    check_eq("t1_addr", dmem_addr, 64'h1000);
    check_eq("t1_strb", {56'd0, dmem_strb}, 64'h08);
    check_eq("t1_wdata", dmem_wdata, 64'hAB00_0000);
    check_eq("t1_wen", {63'd0, dmem_wen}, 64'd1);
    check_eq("t1_s3_valid", {63'd0, s3_valid}, 64'd1);
    check_eq("t1_s2_ready", {63'd0, s2_ready}, 64'd1);
    @(negedge g_clk);
    check_eq("t1_s3_wdata", s3_wdata, 64'h1003);
    check_eq("t1_lsu_op", {57'd0, s3_lsu_op}, 64'h06);
    check_eq("t1_s3_full", {63'd0, s3_full}, 64'd1);
    check_eq("t1_s3_pc", s3_pc, 64'h80);

    // Word load, grant after three wait cycles
    drive_op(64'h84, 1'b1, 1'b0, SIZE_WORD, 64'h2004, 64'h0, 5'd7);
    dmem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_gnt = 1'b1;
      #1;
      check_eq("t2_req", {63'd0, dmem_req}, 64'd1);
      check_eq("t2_addr", dmem_addr, 64'h2000);
      check_eq("t2_strb", {56'd0, dmem_strb}, 64'hF0);
      check_eq("t2_s2_ready", {63'd0, s2_ready}, (i == 3) ? 64'd1 : 64'd0);
      check_eq("t2_s3_valid", {63'd0, s3_valid}, (i == 3) ? 64'd1 : 64'd0);
      @(negedge g_clk);
    end
    dmem_gnt = 1'b0;
    check_eq("t2_s3_wdata", s3_wdata, 64'h2004);
    check_eq("t2_lsu_op", {57'd0, s3_lsu_op}, 64'h11);
    check_eq("t2_s3_rd", {59'd0, s3_rd}, 64'd7);
    check_eq("t2_s3_full", {63'd0, s3_full}, 64'd1);

    // Misaligned half load, misaligned double store, upstream trap priority
    drive_op(64'h88, 1'b1, 1'b0, SIZE_HALF, 64'h3001, 64'h0, 5'd9);
    #1;
    check_eq("t3_ld_req", {63'd0, dmem_req}, 64'd0);
    check_eq("t3_ld_s2_ready", {63'd0, s2_ready}, 64'd1);
    @(negedge g_clk);
    check_eq("t3_ld_trap", {63'd0, s3_trap}, 64'd1);
    check_eq("t3_ld_rd", {59'd0, s3_rd}, 64'd4);
    drive_op(64'h8C, 1'b0, 1'b1, SIZE_DOUBLE, 64'h3004, 64'h55, 5'd9);
    #1;
    check_eq("t3_st_req", {63'd0, dmem_req}, 64'd0);
    @(negedge g_clk);
    check_eq("t3_st_trap", {63'd0, s3_trap}, 64'd1);
    check_eq("t3_st_rd", {59'd0, s3_rd}, 64'd6);
    drive_op(64'h90, 1'b1, 1'b0, SIZE_HALF, 64'h3001, 64'h0, 5'd9);
    s2_trap = 1'b1; s2_cause = 5'd1;
    #1;
    check_eq("t3_tp_req", {63'd0, dmem_req}, 64'd0);
    @(negedge g_clk);
    check_eq("t3_tp_rd", {59'd0, s3_rd}, 64'd1);

    // Back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      drive_op(64'h200 + 64'(4 * i), 1'b0, 1'b0, SIZE_BYTE, 64'h7, 64'h5500 + 64'(i),
               5'(i + 1));
      s2_csr_op = CSR_OP_W'(i + 2);
      #1;
      check_eq("t5_s2_ready", {63'd0, s2_ready}, 64'd1);
      check_eq("t5_req", {63'd0, dmem_req}, 64'd0);
      @(negedge g_clk);
      check_eq("t5_s3_wdata", s3_wdata, 64'h5500 + 64'(i));
      check_eq("t5_s3_rd", {59'd0, s3_rd}, 64'(i + 1));
      check_eq("t5_csr_op", {61'd0, s3_csr_op}, 64'(i + 2));
      check_eq("t5_s3_full", {63'd0, s3_full}, 64'd1);
      check_eq("t5_lsu_op", {57'd0, s3_lsu_op}, 64'd0);
    end

    // Flush in IDLE with writeback stalled
    drive_op(64'h300, 1'b0, 1'b0, SIZE_BYTE, 64'h0, 64'h99, 5'd2);
    flush = 1'b1; s3_ready = 1'b0;
    #1;
    check_eq("fi_s2_ready", {63'd0, s2_ready}, 64'd1);
    check_eq("fi_s3_valid", {63'd0, s3_valid}, 64'd0);
    @(negedge g_clk);
    flush = 1'b0; s3_ready = 1'b1;
    check_eq("fi_s3_full", {63'd0, s3_full}, 64'd0);
    check_eq("fi_s3_pc", s3_pc, 64'h20C);

    // Flush while waiting for grant: REQ -> DRAIN -> IDLE
    drive_op(64'h400, 1'b0, 1'b1, SIZE_WORD, 64'h4000, 64'h1234_5678, 5'd0);
    #1;
    check_eq("t4_req0", {63'd0, dmem_req}, 64'd1);
    @(negedge g_clk);
    flush = 1'b1;
    #1;
    check_eq("t4_req1", {63'd0, dmem_req}, 64'd1);
    check_eq("t4_addr1", dmem_addr, 64'h4000);
    check_eq("t4_s3_valid1", {63'd0, s3_valid}, 64'd0);
    check_eq("t4_s2_ready1", {63'd0, s2_ready}, 64'd0);
    @(negedge g_clk);
    flush = 1'b0;
    #1;
    check_eq("t4_req2", {63'd0, dmem_req}, 64'd1);
    check_eq("t4_wdata2", dmem_wdata, 64'h1234_5678);
    check_eq("t4_s3_valid2", {63'd0, s3_valid}, 64'd0);
    check_eq("t4_s2_ready2", {63'd0, s2_ready}, 64'd0);
    check_eq("t4_s3_full2", {63'd0, s3_full}, 64'd0);
    @(negedge g_clk);
    dmem_gnt = 1'b1;
    #1;
    check_eq("t4_req3", {63'd0, dmem_req}, 64'd1);
    check_eq("t4_s2_ready3", {63'd0, s2_ready}, 64'd1);
    check_eq("t4_s3_valid3", {63'd0, s3_valid}, 64'd0);
    @(negedge g_clk);
    dmem_gnt = 1'b0;
    check_eq("t4_s3_pc_kept", s3_pc, 64'h20C);
    drive_op(64'h500, 1'b0, 1'b0, SIZE_BYTE, 64'h0, 64'h77, 5'd4);
    #1;
    check_eq("t4_idle_valid", {63'd0, s3_valid}, 64'd1);
    @(negedge g_clk);
    check_eq("t4_idle_pc", s3_pc, 64'h500);

    // Reset while in REQ
    drive_op(64'h600, 1'b1, 1'b0, SIZE_DOUBLE, 64'h5000, 64'h0, 5'd5);
    #1;
    check_eq("t6_req0", {63'd0, dmem_req}, 64'd1);
    @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    check_eq("t6_req_rst", {63'd0, dmem_req}, 64'd0);
    @(negedge g_clk);
    g_resetn = 1'b1;
    check_eq("t6_s3_full", {63'd0, s3_full}, 64'd0);
    check_eq("t6_s3_pc", s3_pc, 64'd0);
    check_eq("t6_s3_wdata", s3_wdata, 64'd0);
    drive_op(64'h700, 1'b0, 1'b0, SIZE_BYTE, 64'h0, 64'h1, 5'd1);
    #1;
    check_eq("t6_idle_valid", {63'd0, s3_valid}, 64'd1);
    check_eq("t6_idle_req", {63'd0, dmem_req}, 64'd0);
    @(negedge g_clk);
    idle_inputs();
    @(negedge g_clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
